// File: rtl/acc_int_adder.sv
// Exact registered integer adder: operand registers, full-carry add, registered sum/carry/overflow.
// Optional low-segment hold of the input and output registers when ACC_INT_ADD_LOWGATE_EN is defined.
module acc_int_adder #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int CLKGATED_BITWIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef ACC_INT_ADD_LOWGATE_EN
    input  logic                          reg_en,
`endif
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    output logic [DATA_PATH_BITWIDTH-1:0] c,
    output logic                          cout,
    output logic                          ovf
);

    localparam int N = DATA_PATH_BITWIDTH;

    // Bits set in this mask always load; cleared bits form the holdable low segment.
    localparam logic [N-1:0] HIGH_MASK = {N{1'b1}} << CLKGATED_BITWIDTH;

    // Two's-complement overflow: like-signed operands produce a differently-signed sum.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    logic [N-1:0] a_r;
    logic [N-1:0] b_r;
    logic [N:0]   sum_full_s;
    logic         low_en_s;
    logic [N-1:0] load_mask_s;
    logic [N-1:0] a_next_s;
    logic [N-1:0] b_next_s;
    logic [N-1:0] c_next_s;

`ifdef ACC_INT_ADD_LOWGATE_EN
    logic en_q_r;

    // Enable register: reg_en sampled at one edge governs low-segment loads at the next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q_r <= 1'b0;
        end else begin
            en_q_r <= reg_en;
        end
    end

    assign low_en_s = en_q_r;
`else
    assign low_en_s = 1'b1;
`endif

    // Full-width add; the upper part sees the (possibly held) low operand bits and their carry.
    assign sum_full_s = {1'b0, a_r} + {1'b0, b_r};

    // Merge fresh data with held low bits according to the current enable.
    always_comb begin
        load_mask_s = {N{1'b1}};
        if (low_en_s) begin
            load_mask_s = {N{1'b1}};
        end else begin
            load_mask_s = HIGH_MASK;
        end
        a_next_s = (a & load_mask_s) | (a_r & ~load_mask_s);
        b_next_s = (b & load_mask_s) | (b_r & ~load_mask_s);
        c_next_s = (sum_full_s[N-1:0] & load_mask_s) | (c & ~load_mask_s);
    end

    // Operand and result pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r  <= {N{1'b0}};
            b_r  <= {N{1'b0}};
            c    <= {N{1'b0}};
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            a_r  <= a_next_s;
            b_r  <= b_next_s;
            c    <= c_next_s;
            cout <= sum_full_s[N];
            ovf  <= signed_ovf(a_r[N-1], b_r[N-1], sum_full_s[N-1]);
        end
    end

endmodule

// File: tb/tb_acc_int_adder.sv
// Directed self-checking bench for acc_int_adder (N = 32, G = 16); gating scenarios run
// only when ACC_INT_ADD_LOWGATE_EN is defined.
module tb_acc_int_adder;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic         cout;
    logic         ovf;
`ifdef ACC_INT_ADD_LOWGATE_EN
    logic         reg_en;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] sa [100];
    logic [N-1:0] sb [100];

    always #5 clk = ~clk;

    acc_int_adder #(
        .DATA_PATH_BITWIDTH(32),
        .CLKGATED_BITWIDTH (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef ACC_INT_ADD_LOWGATE_EN
        .reg_en(reg_en),
`endif
        .a     (a),
        .b     (b),
        .c     (c),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result packed as {cout, ovf, sum}.
    function automatic logic [N+1:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] full;
        logic       v;
        full = {1'b0, x} + {1'b0, y};
        v    = (x[N-1] == y[N-1]) && (full[N-1] != x[N-1]);
        return {full[N], v, full[N-1:0]};
    endfunction

    initial begin
        rst = 1'b0;
        a   = '0;
        b   = '0;
`ifdef ACC_INT_ADD_LOWGATE_EN
        reg_en = 1'b1;
`endif
        for (int i = 0; i < 100; i++) begin
            sa[i] = $urandom;
            sb[i] = $urandom;
        end

        // Reset held with toggling operands
        #2;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            step();
            check_eq("reset_hold", {30'd0, cout, ovf, c}, 64'd0);
        end

        // Release with 5 + 7
        a   = 32'd5;
        b   = 32'd7;
        rst = 1'b1;
        step();
`ifdef ACC_INT_ADD_LOWGATE_EN
        step();
`endif
        step();
        check_eq("reset_release", {30'd0, cout, ovf, c}, 64'd12);

        // Directed vectors, expected {cout, ovf, c}
        a = 32'h0000_FFFF; b = 32'h0000_0001; step(); step();
        check_eq("carry_into_bit16", {30'd0, cout, ovf, c}, {30'd0, 1'b0, 1'b0, 32'h0001_0000});
        a = 32'hFFFF_FFFF; b = 32'h0000_0002; step(); step();
        check_eq("wrap_carry", {30'd0, cout, ovf, c}, {30'd0, 1'b1, 1'b0, 32'h0000_0001});
        a = 32'h7FFF_FFFF; b = 32'h0000_0001; step(); step();
        check_eq("pos_overflow", {30'd0, cout, ovf, c}, {30'd0, 1'b0, 1'b1, 32'h8000_0000});
        a = 32'h8000_0000; b = 32'h8000_0000; step(); step();
        check_eq("neg_overflow", {30'd0, cout, ovf, c}, {30'd0, 1'b1, 1'b1, 32'h0000_0000});
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; step(); step();
        check_eq("minus1_minus1", {30'd0, cout, ovf, c}, {30'd0, 1'b1, 1'b0, 32'hFFFF_FFFE});

        // Back-to-back stream, result of pair i-1 visible after the edge sampling pair i
        for (int i = 0; i <= 100; i++) begin
            if (i < 100) begin
                a = sa[i];
                b = sb[i];
            end
            step();
            if (i >= 1) begin
                check_eq($sformatf("stream_%0d", i - 1), {30'd0, cout, ovf, c},
                         {30'd0, ref_add(sa[i-1], sb[i-1])});
            end
        end

`ifdef ACC_INT_ADD_LOWGATE_EN
        // Low-segment hold
        reg_en = 1'b1;
        a = 32'h0001_0003; b = 32'h0002_0004; step(); step();
        check_eq("gate_enabled", {30'd0, cout, ovf, c}, {30'd0, 1'b0, 1'b0, 32'h0003_0007});
        reg_en = 1'b0;
        step();
        a = 32'h0005_FFFF; b = 32'h0006_0001; step(); step();
        check_eq("gate_held", {30'd0, cout, ovf, c}, {30'd0, 1'b0, 1'b0, 32'h000B_0007});
        reg_en = 1'b1;
        step(); step(); step();
        check_eq("gate_restored", {30'd0, cout, ovf, c}, {30'd0, 1'b0, 1'b0, 32'h000C_0000});
`endif

        // Asynchronous reset while results are in flight
        a = 32'h1111_1111; b = 32'h2222_2222; step();
        a = 32'h0000_0001; b = 32'h0000_0002; step();
        check_eq("pre_reset_out", {30'd0, cout, ovf, c}, {30'd0, 1'b0, 1'b0, 32'h3333_3333});
        rst = 1'b0;
        #1;
        check_eq("async_clear", {30'd0, cout, ovf, c}, 64'd0);
        step();
        check_eq("reset_held_edge", {30'd0, cout, ovf, c}, 64'd0);
        a   = 32'h0000_0100;
        b   = 32'h0000_0023;
        rst = 1'b1;
        step();
        check_eq("no_stale", {30'd0, cout, ovf, c}, 64'd0);
`ifdef ACC_INT_ADD_LOWGATE_EN
        step();
`endif
        step();
        check_eq("first_after_reset", {30'd0, cout, ovf, c}, 64'h123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
